alu_decode_stage: RTL and testbench
===================================

Name: alu_decode_stage

Overview:
- Registered decode stage that turns a fetched RV32I instruction word into the 4-bit ALU `Operation` code, the immediate, register indices and datapath control bits consumed by the execute stage.
- Sits between fetch and execute. It is the producer side of the ALU `Operation` interface.
- Uses valid/ready handshakes on both sides, a one-entry pipeline register, a flush input, and a saturating illegal-instruction counter.

Parameters:
- DATA_WIDTH, 32, immediate width. Must be 32.
- INSTR_WIDTH, 32, instruction word width.
- OPCODE_LENGTH, 4, width of `Operation`.
- ILL_CNT_WIDTH, 16, illegal-instruction counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  kill stage contents and incoming instruction
- in_valid  in  1  in_instr valid
- in_ready  out  1  stage can accept this cycle
- in_instr  in  INSTR_WIDTH  instruction word
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- Operation  out  OPCODE_LENGTH  ALU operation code
- imm  out  DATA_WIDTH  sign-extended/shifted immediate
- rs1, rs2, rd  out  5 each  register indices
- alu_src_imm  out  1  SrcB = imm (else rs2 data)
- reg_write, mem_read, mem_write, branch, jump  out  1 each  control
- illegal  out  1  bundle is an unsupported encoding
- ill_count  out  ILL_CNT_WIDTH  illegal instructions accepted, saturating

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (reset).
- Reset values:
  - out_valid=0, ill_count=0, Operation=4'b1111.
  - All other outputs 0.
  - in_ready=1 the cycle after reset deasserts.
- Reset mid-transfer: the held bundle is dropped with no output handshake.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready && !flush. The bundle is registered and appears with out_valid=1 the next cycle (latency 1).
  - Full throughput: back-to-back accepts while out_ready=1.
  - Output handshake completes on out_valid && out_ready. With no new accept, out_valid falls next cycle.
  - out_valid && !out_ready: every output is held bit-stable and in_ready=0.
- Flush:
  - out_valid<=0 next cycle, and any in_valid instruction that cycle is discarded.
  - Flush has priority over accept and over backpressure.
  - ill_count is not incremented for a discarded instruction.
- Operation codes:
  - AND=0000, OR=0001, ADD=0010, SUB=0011, XOR=0110, EQ=1000, NE=1001, LT=1010, PASS1=0101 (LUI/JAL), NOP=1111.
- Decode (opcode[6:0], funct3, funct7):
  - 0110011 R-type, alu_src_imm=0, reg_write=1.
    - f3 000 with f7 0000000 → ADD; f3 000 with f7 0100000 → SUB.
    - f3 111 → AND, f3 110 → OR, f3 100 → XOR. Any f7 other than 0000000 on AND/OR/XOR is illegal.
  - 0010011 I-type, I-immediate, alu_src_imm=1, reg_write=1: f3 000 → ADD, 111 → AND, 110 → OR, 100 → XOR.
  - 0000011 with f3 010 (LW): ADD, I-immediate, alu_src_imm=1, mem_read=1, reg_write=1.
  - 0100011 with f3 010 (SW): ADD, S-immediate, alu_src_imm=1, mem_write=1.
  - 1100011 branches, B-immediate, alu_src_imm=0, branch=1: f3 000 → EQ, 001 → NE, 100 → LT.
  - 0110111 LUI: PASS1, imm={instr[31:12],12'b0}, alu_src_imm=1, reg_write=1.
  - 1101111 JAL: PASS1, J-immediate, jump=1, reg_write=1.
  - Anything else:
    - illegal=1, Operation=NOP.
    - All control bits 0; rs1/rs2/rd/imm still carry the raw instruction fields.
    - ill_count increments on accept and saturates at all-ones with no wrap.
- Immediates are sign-extended from instr[31]. B and J immediates have bit 0 forced to 0.
- rs1/rs2/rd always come from instr[19:15], [24:20], [11:7], regardless of type.

Decomposition:
- Package alu_decode_pkg holds:
  - Opcode localparams (OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL).
  - A typedef enum logic[3:0] for Operation codes.
  - A packed struct typedef for the decoded bundle.
- One sub-module, imm_gen: combinational, takes the instruction word and an immediate-type select, returns a 32-bit immediate.
- Decode logic and the pipeline register live in alu_decode_stage.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), in_valid=1, out_ready=1 → next cycle out_valid=1, Operation=0010, rd=3, rs1=1, rs2=2, reg_write=1, alu_src_imm=0.
- SUB x5,x6,x7 (0x407302B3), then ADDI x1,x0,-1 (0xFFF00093) back-to-back → Operation 0011, then 0010 with imm=0xFFFFFFFF and alu_src_imm=1, on consecutive cycles.
- BEQ x1,x2,-8 (0xFE208CE3) → Operation=1000, imm=0xFFFFFFF8, branch=1, reg_write=0.
- LUI x1,0x12345 (0x123450B7) with out_ready=0 for 3 cycles → Operation=0101, imm=0x12345000; outputs stable and in_ready=0 until out_ready=1.
- 0x00000000 accepted → illegal=1, Operation=1111, ill_count=1. Then 0x00000000 with flush=1 → out_valid=0 next cycle, ill_count stays 1.
- Assert reset while out_valid=1 and out_ready=0 → next cycle out_valid=0 and ill_count=0.

Source files
------------

// File: rtl/alu_decode_pkg.sv
// Shared types for the RV32I decode stage: opcodes, ALU operation codes,
// immediate formats and the registered decode bundle.
package alu_decode_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SUB   = 4'b0011,
    ALU_PASS1 = 4'b0101,
    ALU_XOR   = 4'b0110,
    ALU_EQ    = 4'b1000,
    ALU_NE    = 4'b1001,
    ALU_LT    = 4'b1010,
    ALU_NOP   = 4'b1111
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_e;

  typedef struct packed {
    alu_op_e     operation;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        alu_src_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } decode_bundle_t;

  localparam decode_bundle_t BUNDLE_RESET = '{
    operation:   ALU_NOP,
    imm:         32'd0,
    rs1:         5'd0,
    rs2:         5'd0,
    rd:          5'd0,
    alu_src_imm: 1'b0,
    reg_write:   1'b0,
    mem_read:    1'b0,
    mem_write:   1'b0,
    branch:      1'b0,
    jump:        1'b0,
    illegal:     1'b0
  };

  // Immediate format follows the major opcode alone; R-type and unknown
  // opcodes expose the raw instr[31:20] field as an I-immediate.
  function automatic imm_sel_e imm_sel_of(input logic [6:0] opcode);
    imm_sel_e sel;
    case (opcode)
      OP_STORE:  sel = IMM_S;
      OP_BRANCH: sel = IMM_B;
      OP_LUI:    sel = IMM_U;
      OP_JAL:    sel = IMM_J;
      default:   sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_decode_stage_imm_gen.sv
// Combinational RV32I immediate generator: sign-extends from instr[31],
// B and J immediates carry an implicit zero in bit 0.
module imm_gen
  import alu_decode_pkg::*;
(
  input  logic [31:0] instr,
  input  imm_sel_e    sel,
  output logic [31:0] imm
);

  logic unused_opcode_bits;
  assign unused_opcode_bits = ^instr[6:0];

  always_comb begin
    case (sel)
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

endmodule

// File: rtl/alu_decode_stage.sv
// RV32I decode stage: combinational decode into a one-entry valid/ready
// pipeline register, with flush and a saturating illegal-instruction counter.
module alu_decode_stage
  import alu_decode_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int INSTR_WIDTH   = 32,
  parameter int OPCODE_LENGTH = 4,
  parameter int ILL_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_WIDTH-1:0]   in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic [DATA_WIDTH-1:0]    imm,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [4:0]               rd,
  output logic                     alu_src_imm,
  output logic                     reg_write,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic                     branch,
  output logic                     jump,
  output logic                     illegal,
  output logic [ILL_CNT_WIDTH-1:0] ill_count
);

  logic [6:0]     opcode;
  logic [2:0]     funct3;
  logic [6:0]     funct7;
  imm_sel_e       imm_sel;
  logic [31:0]    imm_val;
  decode_bundle_t dec;
  decode_bundle_t held;
  logic           accept;

  assign opcode  = in_instr[6:0];
  assign funct3  = in_instr[14:12];
  assign funct7  = in_instr[31:25];
  assign imm_sel = imm_sel_of(opcode);

  imm_gen u_imm_gen (
    .instr (in_instr),
    .sel   (imm_sel),
    .imm   (imm_val)
  );

  always_comb begin
    // NOTE: every field gets a default before the case, so no path can
    // leave a field unassigned and infer a latch.
    dec           = '0;
    dec.operation = ALU_NOP;
    dec.imm       = imm_val;
    dec.rs1       = in_instr[19:15];
    dec.rs2       = in_instr[24:20];
    dec.rd        = in_instr[11:7];

    case (opcode)
      OP_RTYPE: begin
        dec.reg_write = 1'b1;
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000)      dec.operation = ALU_ADD;
            else if (funct7 == 7'b0100000) dec.operation = ALU_SUB;
            else                           dec.illegal   = 1'b1;
          end
          3'b111:  dec.operation = ALU_AND;
          3'b110:  dec.operation = ALU_OR;
          3'b100:  dec.operation = ALU_XOR;
          default: dec.illegal   = 1'b1;
        endcase
        if (funct3 != 3'b000 && funct7 != 7'b0000000) dec.illegal = 1'b1;
      end
      OP_ITYPE: begin
        dec.alu_src_imm = 1'b1;
        dec.reg_write   = 1'b1;
        case (funct3)
          3'b000:  dec.operation = ALU_ADD;
          3'b111:  dec.operation = ALU_AND;
          3'b110:  dec.operation = ALU_OR;
          3'b100:  dec.operation = ALU_XOR;
          default: dec.illegal   = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec.operation   = ALU_ADD;
        dec.alu_src_imm = 1'b1;
        dec.mem_read    = 1'b1;
        dec.reg_write   = 1'b1;
        dec.illegal     = (funct3 != 3'b010);
      end
      OP_STORE: begin
        dec.operation   = ALU_ADD;
        dec.alu_src_imm = 1'b1;
        dec.mem_write   = 1'b1;
        dec.illegal     = (funct3 != 3'b010);
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        case (funct3)
          3'b000:  dec.operation = ALU_EQ;
          3'b001:  dec.operation = ALU_NE;
          3'b100:  dec.operation = ALU_LT;
          default: dec.illegal   = 1'b1;
        endcase
      end
      OP_LUI: begin
        dec.operation   = ALU_PASS1;
        dec.alu_src_imm = 1'b1;
        dec.reg_write   = 1'b1;
      end
      OP_JAL: begin
        dec.operation = ALU_PASS1;
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase

    // Unsupported encodings keep the raw fields but must not steer the datapath.
    if (dec.illegal) begin
      dec.operation   = ALU_NOP;
      dec.alu_src_imm = 1'b0;
      dec.reg_write   = 1'b0;
      dec.mem_read    = 1'b0;
      dec.mem_write   = 1'b0;
      dec.branch      = 1'b0;
      dec.jump        = 1'b0;
    end
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // NOTE: the data register is reset as well as out_valid, since every
  // output has a defined reset value visible to the execute stage.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every register samples pre-edge values.
    if (reset) begin
      out_valid <= 1'b0;
      ill_count <= '0;
      held      <= BUNDLE_RESET;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      held      <= dec;
      if (dec.illegal && ill_count != '1) ill_count <= ill_count + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign Operation   = held.operation;
  assign imm         = held.imm;
  assign rs1         = held.rs1;
  assign rs2         = held.rs2;
  assign rd          = held.rd;
  assign alu_src_imm = held.alu_src_imm;
  assign reg_write   = held.reg_write;
  assign mem_read    = held.mem_read;
  assign mem_write   = held.mem_write;
  assign branch      = held.branch;
  assign jump        = held.jump;
  assign illegal     = held.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed cases with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_alu_decode_stage;

  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic [31:0]   in_instr;
  logic          in_ready, out_valid;
  logic [3:0]    Operation;
  logic [31:0]   imm;
  logic [4:0]    rs1, rs2, rd;
  logic          alu_src_imm, reg_write, mem_read, mem_write, branch, jump, illegal;
  logic [CW-1:0] ill_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_decode_stage #(.ILL_CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .Operation(Operation), .imm(imm), .rs1(rs1), .rs2(rs2), .rd(rd),
    .alu_src_imm(alu_src_imm), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .jump(jump), .illegal(illegal),
    .ill_count(ill_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        src, rw, mr, mw, br, jp, ill;
  } exp_t;

  // Reference decode written from the instruction-set rules, by mnemonic class.
  function automatic exp_t model(input logic [31:0] w);
    exp_t  e;
    string cls;
    int    opc, f3, f7, op, v;
    opc = int'(w[6:0]);
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    op  = 15;
    cls = "ILL";
    case (opc)
      'h33: begin
        cls = "R";
        if (f3 == 0 && f7 == 0)       op = 2;
        else if (f3 == 0 && f7 == 32) op = 3;
        else if (f3 == 7 && f7 == 0)  op = 0;
        else if (f3 == 6 && f7 == 0)  op = 1;
        else if (f3 == 4 && f7 == 0)  op = 6;
        else                          cls = "ILL";
      end
      'h13: begin
        cls = "I";
        if (f3 == 0)      op = 2;
        else if (f3 == 7) op = 0;
        else if (f3 == 6) op = 1;
        else if (f3 == 4) op = 6;
        else              cls = "ILL";
      end
      'h03: if (f3 == 2) begin cls = "LW"; op = 2; end
      'h23: if (f3 == 2) begin cls = "SW"; op = 2; end
      'h63: begin
        cls = "B";
        if (f3 == 0)      op = 8;
        else if (f3 == 1) op = 9;
        else if (f3 == 4) op = 10;
        else              cls = "ILL";
      end
      'h37: begin cls = "LUI"; op = 5; end
      'h6F: begin cls = "JAL"; op = 5; end
      default: cls = "ILL";
    endcase

    case (opc)
      'h23: begin v = int'({w[31:25], w[11:7]}); if (w[31]) v -= 4096; end
      'h63: begin v = int'({w[31], w[7], w[30:25], w[11:8], 1'b0}); if (w[31]) v -= 8192; end
      'h37: v = int'(w & 32'hFFFFF000);
      'h6F: begin v = int'({w[31], w[19:12], w[20], w[30:21], 1'b0}); if (w[31]) v -= (1 << 21); end
      default: begin v = int'(w[31:20]); if (w[31]) v -= 4096; end
    endcase

    e.imm = 32'(v);
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd  = w[11:7];
    e.src = (cls == "I" || cls == "LW" || cls == "SW" || cls == "LUI");
    e.rw  = (cls == "R" || cls == "I" || cls == "LW" || cls == "LUI" || cls == "JAL");
    e.mr  = (cls == "LW");
    e.mw  = (cls == "SW");
    e.br  = (cls == "B");
    e.jp  = (cls == "JAL");
    e.ill = (cls == "ILL");
    e.op  = e.ill ? 4'hF : 4'(op);
    return e;
  endfunction

  function automatic exp_t reset_bundle();
    exp_t e;
    e = '{op: 4'hF, imm: 32'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
          src: 1'b0, rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0, jp: 1'b0, ill: 1'b0};
    return e;
  endfunction

  // Model state: what the stage must be holding after each edge.
  logic started = 1'b0;
  logic m_valid, m_fresh;
  int   m_cnt;
  exp_t m_b;

  always @(posedge clk) begin
    if (reset) begin
      started <= 1'b1;
      m_valid <= 1'b0;
      m_fresh <= 1'b1;
      m_cnt   <= 0;
      m_b     <= reset_bundle();
    end else if (started) begin
      if (flush) begin
        m_valid <= 1'b0;
      end else if (in_valid && (!m_valid || out_ready)) begin
        m_valid <= 1'b1;
        m_fresh <= 1'b0;
        m_b     <= model(in_instr);
        if (model(in_instr).ill && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      check("ill_count", 32'(ill_count), 32'(m_cnt));
      if (m_valid || m_fresh) begin
        check("Operation", 32'(Operation), 32'(m_b.op));
        check("imm", imm, m_b.imm);
        check("regs", 32'({rs1, rs2, rd}), 32'({m_b.rs1, m_b.rs2, m_b.rd}));
        check("ctrl", 32'({alu_src_imm, reg_write, mem_read, mem_write, branch, jump, illegal}),
              32'({m_b.src, m_b.rw, m_b.mr, m_b.mw, m_b.br, m_b.jp, m_b.ill}));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  opcs [7];
    int          pick;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h6F};
    w    = $urandom;
    pick = $urandom_range(0, 8);
    if (pick < 7) begin
      w[6:0] = opcs[pick];
      if ($urandom_range(0, 1) == 0) w[14:12] = 3'b010;
      if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
    end
    return w;
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = 32'd0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst Operation", 32'(Operation), 32'hF);
    check("rst imm", imm, 32'd0);
    check("rst ill_count", 32'(ill_count), 32'd0);
    check("rst in_ready", 32'(in_ready), 32'd1);

    in_valid = 1'b1; in_instr = 32'h002081B3;
    cyc();
    check("add valid", 32'(out_valid), 32'd1);
    check("add op", 32'(Operation), 32'h2);
    check("add regs", 32'({rd, rs1, rs2}), 32'({5'd3, 5'd1, 5'd2}));
    check("add ctrl", 32'({reg_write, alu_src_imm}), 32'b10);

    in_instr = 32'h407302B3;
    cyc();
    check("sub op", 32'(Operation), 32'h3);
    in_instr = 32'hFFF00093;
    cyc();
    check("addi op", 32'(Operation), 32'h2);
    check("addi imm", imm, 32'hFFFFFFFF);
    check("addi src", 32'(alu_src_imm), 32'd1);

    in_instr = 32'hFE208CE3;
    cyc();
    check("beq op", 32'(Operation), 32'h8);
    check("beq imm", imm, 32'hFFFFFFF8);
    check("beq ctrl", 32'({branch, reg_write}), 32'b10);

    in_instr = 32'h123450B7;
    cyc();
    out_ready = 1'b0; in_instr = 32'h002081B3;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("lui op", 32'(Operation), 32'h5);
      check("lui imm", imm, 32'h12345000);
      check("lui stall in_ready", 32'(in_ready), 32'd0);
      check("lui stall valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    #1;
    check("lui release in_ready", 32'(in_ready), 32'd1);
    cyc();
    check("drain valid", 32'(out_valid), 32'd0);

    in_valid = 1'b1; in_instr = 32'h00000000;
    cyc();
    check("ill flag", 32'(illegal), 32'd1);
    check("ill op", 32'(Operation), 32'hF);
    check("ill count", 32'(ill_count), 32'd1);
    flush = 1'b1;
    cyc();
    check("flush valid", 32'(out_valid), 32'd0);
    check("flush count", 32'(ill_count), 32'd1);
    flush = 1'b0;

    in_instr = 32'h002081B3; out_ready = 1'b0;
    cyc();
    check("pre-reset valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0; reset = 1'b1;
    cyc();
    check("midrst valid", 32'(out_valid), 32'd0);
    check("midrst count", 32'(ill_count), 32'd0);
    reset = 1'b0; out_ready = 1'b1;

    in_valid = 1'b1; in_instr = 32'hFFFFFFFF;
    for (int i = 0; i < CNT_MAX + 5; i++) cyc();
    check("sat count", 32'(ill_count), 32'(CNT_MAX));
    check("sat rd", 32'(rd), 32'd31);
    check("sat imm", imm, 32'hFFFFFFFF);

    reset = 1'b1; in_valid = 1'b0;
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
